// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a FIFO behind a valid/ready write port feeding a
// framer with configurable data width, parity and stop bits.
module uart_tx_fifo #(
  parameter int CLK_PER_BAUD = 2604,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLK_PER_BAUD);

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_PER_BAUD - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  if (CLK_PER_BAUD < 2) begin : g_bad_cpb
    $error("uart_tx_fifo: CLK_PER_BAUD must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_fifo: DATA_BITS must be in 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count;

  logic [2:0]           state;
  logic [BW-1:0]        baud_cnt;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit;

  logic                 push;
  logic                 pop;
  logic                 bit_end;
  logic                 last_stop;
  logic [DATA_BITS-1:0] head;
  logic                 head_par;

  assign tx_ready   = (count != CNT_FULL);
  assign fifo_count = count;
  assign busy       = (state != S_IDLE);

  assign head      = mem[rd_ptr];
  assign head_par  = (PARITY == 2) ? (^head) : ~(^head);
  assign bit_end   = (baud_cnt == BAUD_LAST);
  assign last_stop = (state == S_STOP) && bit_end && (bit_idx == STOP_LAST);

  assign push = tx_valid && tx_ready;
  // A pop happens only where the framer starts a new frame: from IDLE, or
  // straight out of the final stop bit so back-to-back frames have no gap.
  assign pop  = (count != '0) && ((state == S_IDLE) || last_stop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != S_IDLE) begin
        baud_cnt <= bit_end ? '0 : baud_cnt + BW'(1);
      end
      case (state)
        S_IDLE: begin
          if (pop) begin
            state    <= S_START;
            shift    <= head;
            par_bit  <= head_par;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= 1'b0;
          end
        end
        S_START: begin
          if (bit_end) begin
            state   <= S_DATA;
            bit_idx <= '0;
            tx      <= shift[0];
            shift   <= shift >> 1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
              if (PARITY != 0) begin
                state <= S_PAR;
                tx    <= par_bit;
              end else begin
                state <= S_STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 4'd1;
              tx      <= shift[0];
              shift   <= shift >> 1;
            end
          end
        end
        S_PAR: begin
          if (bit_end) begin
            state   <= S_STOP;
            bit_idx <= '0;
            tx      <= 1'b1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (bit_idx == STOP_LAST) begin
              done    <= 1'b1;
              bit_idx <= '0;
              if (pop) begin
                state   <= S_START;
                shift   <= head;
                par_bit <= head_par;
                tx      <= 1'b0;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four configurations share one stimulus stream; a
// per-instance serial monitor decodes each frame against queued words.
module tb_uart_tx_fifo;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] tx_data = '0;
  logic       tx_valid = 1'b0;

  logic       tx_w   [4];
  logic       busy_w [4];
  logic       done_w [4];
  logic       rdy_w  [4];
  logic [2:0] cnt_w  [4];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // 0: 8N1   1: 8E1   2: 8O1   3: 7O2
  uart_tx_fifo #(.CLK_PER_BAUD(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .rst(rst), .tx_data(tx_data[7:0]), .tx_valid(tx_valid), .tx_ready(rdy_w[0]),
    .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]), .fifo_count(cnt_w[0]));
  uart_tx_fifo #(.CLK_PER_BAUD(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .tx_data(tx_data[7:0]), .tx_valid(tx_valid), .tx_ready(rdy_w[1]),
    .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]), .fifo_count(cnt_w[1]));
  uart_tx_fifo #(.CLK_PER_BAUD(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .rst(rst), .tx_data(tx_data[7:0]), .tx_valid(tx_valid), .tx_ready(rdy_w[2]),
    .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]), .fifo_count(cnt_w[2]));
  uart_tx_fifo #(.CLK_PER_BAUD(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut3 (
    .clk(clk), .rst(rst), .tx_data(tx_data[6:0]), .tx_valid(tx_valid), .tx_ready(rdy_w[3]),
    .tx(tx_w[3]), .busy(busy_w[3]), .done(done_w[3]), .fifo_count(cnt_w[3]));

  function automatic int cfg_db(input int d);
    return (d == 3) ? 7 : 8;
  endfunction

  function automatic int cfg_par(input int d);
    case (d)
      1:       return 2;
      2, 3:    return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int cfg_stop(input int d);
    return (d == 3) ? 2 : 1;
  endfunction

  function automatic int flen(input int d);
    return (1 + cfg_db(d) + ((cfg_par(d) != 0) ? 1 : 0) + cfg_stop(d)) * CPB;
  endfunction

  // Expected line level for serial bit slot k of a frame carrying word w.
  function automatic logic fbit(input int d, input logic [8:0] w, input int k);
    int   db = cfg_db(d);
    logic p  = 1'b0;
    if (k == 0) return 1'b0;
    if (k <= db) return w[k-1];
    if (cfg_par(d) != 0 && k == db + 1) begin
      for (int i = 0; i < db; i++) p ^= w[i];
      return (cfg_par(d) == 2) ? p : ~p;
    end
    return 1'b1;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  logic [8:0] exp_q [4][$];
  int         done_t0 [$];
  bit         act [4];
  int         cyc [4];
  logic [8:0] cur [4];
  int         ncyc = 0;

  always @(negedge clk) begin
    ncyc++;
    for (int d = 0; d < 4; d++) begin
      if (rst) begin
        act[d] = 1'b0;
      end else begin
        if (act[d]) begin
          cyc[d]++;
          if (done_w[d]) begin
            chk($sformatf("frame_len[%0d]", d), cyc[d], flen(d));
            act[d] = 1'b0;
            if (d == 0) done_t0.push_back(ncyc);
          end else if (cyc[d] >= flen(d)) begin
            chk($sformatf("done_at_end[%0d]", d), done_w[d], 1);
            act[d] = 1'b0;
          end
        end else if (done_w[d]) begin
          chk($sformatf("spurious_done[%0d]", d), done_w[d], 0);
        end
        if (!act[d] && tx_w[d] == 1'b0) begin
          chk($sformatf("frame_expected[%0d]", d), (exp_q[d].size() != 0) ? 1 : 0, 1);
          cur[d] = (exp_q[d].size() != 0) ? exp_q[d].pop_front() : 9'h0;
          act[d] = 1'b1;
          cyc[d] = 0;
        end
        if (act[d]) begin
          chk($sformatf("tx_bit[%0d] slot %0d word %0h", d, cyc[d] / CPB, cur[d]),
              tx_w[d], fbit(d, cur[d], cyc[d] / CPB));
          chk($sformatf("busy_frame[%0d]", d), busy_w[d], 1);
        end else begin
          chk($sformatf("idle_line[%0d]", d), tx_w[d], 1);
          chk($sformatf("idle_busy[%0d]", d), busy_w[d], 0);
        end
      end
    end
  end

  task automatic wr_burst(input int n, input logic [8:0] base, input int n_acc);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      tx_data  = base + 9'(i);
      tx_valid = 1'b1;
      if (i < n_acc) begin
        for (int d = 0; d < 4; d++) exp_q[d].push_back(base + 9'(i));
      end
    end
    @(posedge clk); #1;
    tx_valid = 1'b0;
    tx_data  = 9'h1FF;
  endtask

  task automatic wait_idle(input int maxc);
    bit ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(posedge clk);
      ok = 1'b1;
      for (int d = 0; d < 4; d++) begin
        if (act[d] || exp_q[d].size() != 0) ok = 1'b0;
      end
    end
    chk("wait_idle_timeout", ok, 1);
  endtask

  task automatic chk_reset_state(input string tag);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("%s_tx[%0d]", tag, d), tx_w[d], 1);
      chk($sformatf("%s_busy[%0d]", tag, d), busy_w[d], 0);
      chk($sformatf("%s_done[%0d]", tag, d), done_w[d], 0);
      chk($sformatf("%s_ready[%0d]", tag, d), rdy_w[d], 1);
      chk($sformatf("%s_count[%0d]", tag, d), cnt_w[d], 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values, then a long idle stretch watched by the monitor
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_state("reset");
    repeat (100) @(posedge clk);

    // 8N1 word 0x55 with first-bit latency
    wr_burst(1, 9'h055, 1);
    @(negedge clk);
    chk("latency_early_tx", tx_w[0], 1);
    @(negedge clk);
    chk("latency_start_tx", tx_w[0], 0);
    wait_idle(200);

    // Parity slot for word 0x07 (slot 8 on 7-bit, slot 9 on 8-bit)
    wr_burst(1, 9'h007, 1);
    repeat (35) @(negedge clk);
    chk("par_7bit_odd", tx_w[3], 0);
    repeat (4) @(negedge clk);
    chk("par_none_stop", tx_w[0], 1);
    chk("par_even", tx_w[1], 1);
    chk("par_odd", tx_w[2], 0);
    chk("par_7bit_stop", tx_w[3], 1);
    wait_idle(200);

    // FIFO full: six writes, first five accepted, sixth dropped
    done_t0.delete();
    wr_burst(6, 9'h0A0, 5);
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("full_ready[%0d]", d), rdy_w[d], 0);
      chk($sformatf("full_count[%0d]", d), cnt_w[d], 4);
    end
    wait_idle(600);
    chk("b2b_done_count", done_t0.size(), 5);
    for (int i = 1; i < 5 && i < done_t0.size(); i++) begin
      chk($sformatf("b2b_done_spacing[%0d]", i), done_t0[i] - done_t0[i-1], 40);
    end

    // Reset during data bit 3 with two words queued
    wr_burst(3, 9'h05A, 3);
    repeat (16) @(posedge clk);
    #1 rst = 1'b1;
    for (int d = 0; d < 4; d++) exp_q[d].delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_state("midrst");
    repeat (60) @(posedge clk);
    wr_burst(1, 9'h03C, 1);
    wait_idle(200);

    // 7O2 word 0x41: 44-cycle frame checked by the monitor
    wr_burst(1, 9'h041, 1);
    wait_idle(200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised, buffered UART transmitter; successor to the fixed 8N1 single-byte transmitter.
- Adds configurable data width, parity mode and stop-bit count.
- Adds a FIFO with a valid/ready write interface, so producers queue bytes without waiting on the serial line.
- Frames go out back-to-back while the FIFO is non-empty.

Parameters:
CLK_PER_BAUD, 2604, clock cycles per serial bit (25 MHz / 9600); must be >= 2
DATA_BITS, 8, data bits per frame, legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits per frame, 1 or 2
FIFO_DEPTH, 16, FIFO entries; power of two, >= 2

Ports:
clk  input  1  system clock, single clock domain
rst  input  1  synchronous reset, active-high
tx_data  input  DATA_BITS  word to enqueue
tx_valid  input  1  tx_data is valid this cycle
tx_ready  output  1  FIFO can accept a word (count != FIFO_DEPTH)
tx  output  1  serial line, idle high, registered
busy  output  1  high while a frame is in progress (FSM not IDLE)
done  output  1  one-cycle pulse in the cycle after the last stop bit ends
fifo_count  output  $clog2(FIFO_DEPTH)+1  words currently queued

Behaviour:
- Reset (rst sampled high at a clk edge):
  - tx=1, busy=0, done=0, fifo_count=0, tx_ready=1.
  - FSM=IDLE; baud counter and bit index cleared; FIFO pointers zeroed.
  - Applies immediately, including mid-frame: no done pulse, queued data discarded.
- Write:
  - Accepted on any edge where tx_valid && tx_ready.
  - tx_ready is combinational from the registered count.
  - Writes while full are ignored; FIFO contents and count stay unchanged.
- Simultaneous push and pop: both happen and fifo_count is unchanged. When full, tx_ready=0, so a same-cycle pop does not admit a push.
- Pointers: wrap modulo FIFO_DEPTH. The extra count bit distinguishes full from empty.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE -> START on an edge where fifo_count != 0. The head word is popped into the shift register on that same edge and tx goes 0.
  - Latency: a word written at edge N into an empty FIFO while IDLE drives tx low after edge N+1.
  - START: tx=0 for CLK_PER_BAUD cycles -> DATA.
  - DATA: DATA_BITS bits, LSB first, each held CLK_PER_BAUD cycles.
  - DATA -> PAR if PARITY != 0, else -> STOP.
  - PAR: one bit, CLK_PER_BAUD cycles.
    - Even: XOR of the data bits.
    - Odd: inverted XOR.
    - Either way the total count of 1s (data plus parity) matches the mode.
  - STOP: tx=1 for STOP_BITS*CLK_PER_BAUD cycles.
  - End of STOP: done=1 for one cycle.
    - If fifo_count != 0, pop and go directly to START on that edge, with no idle gap between frames.
    - Otherwise go to IDLE.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLK_PER_BAUD cycles, exact, with no drift across back-to-back frames.
- Baud counter: counts 0..CLK_PER_BAUD-1 and reloads at each bit boundary. Its width is $clog2(CLK_PER_BAUD).
- busy: equals (state != IDLE). It stays high across back-to-back frames.
- tx_data changes after acceptance have no effect on the queued word.
- Illegal parameter values are rejected at elaboration via assertion.

Test Plan:
1. Reset values (CLK_PER_BAUD=4). Hold rst 3 cycles -> tx=1, busy=0, done=0, tx_ready=1, fifo_count=0; line stays high for 100 idle cycles.
2. 8N1 single word (CLK_PER_BAUD=4). Write 0x55 -> after 1 cycle, tx carries 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles.
   - Total 40 cycles.
   - done pulses once at cycle 40.
   - busy falls with it.
3. Parity, DATA_BITS=8, word 0x07.
   - PARITY=2 (even) -> parity bit 1.
   - PARITY=1 (odd) -> 0.
   - PARITY=0 -> no parity slot; frame is 10*CPB cycles.
4. FIFO full (FIFO_DEPTH=4, CPB=4, idle). Drive tx_valid for 6 consecutive cycles with words 0xA0..0xA5 ->
   - 0xA0..0xA4 accepted (0xA0 popped immediately).
   - tx_ready falls after the 5th write; fifo_count=4; 0xA5 dropped.
   - Five frames go out back-to-back with no idle cycle between stop and start bits.
   - done pulses 5 times, 40 cycles apart.
5. Reset mid-frame: assert rst for 1 cycle during data bit 3 with 2 words queued ->
   - tx=1 on the next cycle; fifo_count=0; busy=0; no done pulse.
   - A following write of 0x3C transmits a clean, correct frame.
6. DATA_BITS=7, STOP_BITS=2, PARITY=1, CPB=4, word 0x41 -> start, 1000001 LSB first, parity 1, stop high 8 cycles; frame length 44 cycles.
